// File: rtl/mc_control.sv
// Multi-cycle control unit for the Lite MIPS32 CPU: sequences fetch, decode,
// execute, memory and write-back, and drives the datapath enables and mux selects.
//
// state  | meaning
// IF     | fetch, IR loads
// ID     | decode, latch opcode/funct; j and illegal retire here
// EXE_R  | R-type ALU operation
// EXE_I  | addi / ori ALU operation
// EXE_LS | lw / sw address calculation
// EXE_BR | beq compare, retire
// MEM_RD | data memory read
// MEM_WR | data memory write, retire
// WB_R   | write rd from ALU result, retire
// WB_I   | write rt from ALU result, retire
// WB_LD  | write rt from DR, retire
// HALT   | stopped until reset
module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Stall,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       MemRd,
  output logic       MemWr,
  output logic       RegDst,
  output logic       WrDataSrc,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       Halted,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_R  = 4'd2,
    S_EXE_I  = 4'd3,
    S_EXE_LS = 4'd4,
    S_EXE_BR = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_R   = 4'd8,
    S_WB_I   = 4'd9,
    S_WB_LD  = 4'd10,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t     state;
  logic [5:0] op_q;
  logic [5:0] funct_q;

  // {valid, alu_op}
  function automatic logic [3:0] funct_dec(input logic [5:0] f);
    case (f)
      6'h20:   return 4'b1000;
      6'h22:   return 4'b1001;
      6'h24:   return 4'b1010;
      6'h25:   return 4'b1011;
      6'h2A:   return 4'b1100;
      default: return 4'b0000;
    endcase
  endfunction

  logic [3:0] id_fdec;
  logic [3:0] ex_fdec;
  assign id_fdec = funct_dec(Funct);
  assign ex_fdec = funct_dec(funct_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IF;
      op_q    <= 6'd0;
      funct_q <= 6'd0;
    end else if (!Stall) begin
      case (state)
        S_IF: state <= S_ID;
        S_ID: begin
          op_q    <= Opcode;
          funct_q <= Funct;
          case (Opcode)
            OP_R:          state <= id_fdec[3] ? S_EXE_R : S_IF;
            OP_ADDI,
            OP_ORI:        state <= S_EXE_I;
            OP_LW,
            OP_SW:         state <= S_EXE_LS;
            OP_BEQ:        state <= S_EXE_BR;
            OP_HALT:       state <= S_HALT;
            default:       state <= S_IF;
          endcase
        end
        S_EXE_R:  state <= S_WB_R;
        S_EXE_I:  state <= S_WB_I;
        S_EXE_LS: state <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: state <= S_WB_LD;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IF;
      endcase
    end
  end

  logic       pc_we, ir_we, reg_we, mem_rd, mem_wr, illegal;
  logic       reg_dst, wr_data_src, alu_src_b, ext_sel;
  logic [2:0] alu_op;
  logic [1:0] pc_src;

  always_comb begin
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    reg_we      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    illegal     = 1'b0;
    reg_dst     = 1'b0;
    wr_data_src = 1'b0;
    alu_src_b   = 1'b0;
    ext_sel     = 1'b0;
    alu_op      = 3'b000;
    pc_src      = 2'b00;

    // ALU selects stay put from EXE through WB so the result latch is stable
    case (state)
      S_EXE_R, S_EXE_I, S_EXE_LS, S_EXE_BR, S_MEM_RD, S_MEM_WR,
      S_WB_R, S_WB_I, S_WB_LD: begin
        case (op_q)
          OP_R:         alu_op = ex_fdec[2:0];
          OP_ADDI:      begin alu_src_b = 1'b1; ext_sel = 1'b1; end
          OP_ORI:       begin alu_src_b = 1'b1; alu_op = 3'b011; end
          OP_LW, OP_SW: begin alu_src_b = 1'b1; ext_sel = 1'b1; end
          OP_BEQ:       begin ext_sel = 1'b1; alu_op = 3'b001; end
          default:      alu_op = 3'b000;
        endcase
      end
      default: alu_op = 3'b000;
    endcase

    case (state)
      S_IF: ir_we = 1'b1;
      S_ID: begin
        case (Opcode)
          OP_J: begin
            pc_we  = 1'b1;
            pc_src = 2'b10;
          end
          OP_R: begin
            if (!id_fdec[3]) begin
              pc_we   = 1'b1;
              illegal = 1'b1;
            end
          end
          OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_HALT: pc_we = 1'b0;
          default: begin
            pc_we   = 1'b1;
            illegal = 1'b1;
          end
        endcase
      end
      S_EXE_BR: begin
        pc_we  = 1'b1;
        pc_src = Zero ? 2'b01 : 2'b00;
      end
      S_MEM_RD: mem_rd = 1'b1;
      S_MEM_WR: begin
        mem_wr = 1'b1;
        pc_we  = 1'b1;
      end
      S_WB_R: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        pc_we   = 1'b1;
      end
      S_WB_I: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
      end
      S_WB_LD: begin
        reg_we      = 1'b1;
        wr_data_src = 1'b1;
        pc_we       = 1'b1;
      end
      default: pc_we = 1'b0;
    endcase
  end

  // enables are gated by reset too, so IRWre stays low while rst_n is held
  logic run;
  assign run = rst_n & ~Stall;

  assign PCWre     = pc_we   & run;
  assign IRWre     = ir_we   & run;
  assign RegWre    = reg_we  & run;
  assign MemRd     = mem_rd  & run;
  assign MemWr     = mem_wr  & run;
  assign IllegalOp = illegal & run;
  assign RegDst    = reg_dst;
  assign WrDataSrc = wr_data_src;
  assign ALUSrcB   = alu_src_b;
  assign ExtSel    = ext_sel;
  assign ALUOp     = alu_op;
  assign PCSrc     = pc_src;
  assign Halted    = (state == S_HALT);
  assign State     = state;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle comparison of every output against
// hand-written expected vectors for each instruction class.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       Stall = 1'b0;
  logic       PCWre, IRWre, RegWre, MemRd, MemWr, RegDst, WrDataSrc;
  logic       ALUSrcB, ExtSel, Halted, IllegalOp;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc;
  logic [3:0] State;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .Stall(Stall), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
    .MemRd(MemRd), .MemWr(MemWr), .RegDst(RegDst), .WrDataSrc(WrDataSrc),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .Halted(Halted), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clk = ~clk;

  wire [19:0] outs = {PCWre, IRWre, RegWre, MemRd, MemWr,
                      RegDst, WrDataSrc, ALUSrcB, ExtSel,
                      ALUOp, PCSrc, Halted, IllegalOp, State};

  int errors = 0;
  int checks = 0;
  logic [19:0] ev  [0:31];
  logic        stl [0:31];

  // we = {PCWre,IRWre,RegWre,MemRd,MemWr}; sel = {RegDst,WrDataSrc,ALUSrcB,ExtSel}
  function automatic logic [19:0] e(input logic [3:0] st, input logic [4:0] we,
                                    input logic [3:0] sel, input logic [2:0] alu,
                                    input logic [1:0] pcs, input logic hl,
                                    input logic ill);
    return {we, sel, alu, pcs, hl, ill, st};
  endfunction

  function automatic logic [19:0] v_if();
    return e(4'd0, 5'b01000, 4'b0000, 3'd0, 2'b00, 1'b0, 1'b0);
  endfunction

  function automatic logic [19:0] v_id();
    return e(4'd1, 5'b00000, 4'b0000, 3'd0, 2'b00, 1'b0, 1'b0);
  endfunction

  task automatic clear_stl();
    foreach (stl[k]) stl[k] = 1'b0;
  endtask

  task automatic test_reset();
    Opcode = 6'b000010;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (outs !== 20'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h", outs, 20'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (outs !== v_if()) begin
      errors++;
      $display("FAIL reset_first_fetch: got %h want %h", outs, v_if());
    end
    @(negedge clk);
    #1;
    checks++;
    if (outs !== e(4'd1, 5'b10000, 4'b0000, 3'd0, 2'b10, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_then_j_id: got %h want %h", outs,
               e(4'd1, 5'b10000, 4'b0000, 3'd0, 2'b10, 1'b0, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_rtype();
    logic [5:0] fn_t [0:4];
    logic [2:0] alu_t [0:4];
    fn_t  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    alu_t = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    clear_stl();
    for (int k = 0; k < 5; k++) begin
      Opcode = 6'b000000;
      Funct  = fn_t[k];
      Zero   = 1'b1;
      ev[0] = v_if();
      ev[1] = v_id();
      ev[2] = e(4'd2, 5'b00000, 4'b0000, alu_t[k], 2'b00, 1'b0, 1'b0);
      ev[3] = e(4'd8, 5'b10100, 4'b1000, alu_t[k], 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
        Stall = stl[i];
        #1;
        checks++;
        if (outs !== ev[i]) begin
          errors++;
          $display("FAIL rtype funct=%h cyc%0d: got %h want %h", fn_t[k], i, outs, ev[i]);
        end
        @(negedge clk);
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_imm();
    logic [5:0] op_t  [0:1];
    logic [3:0] sel_t [0:1];
    logic [2:0] alu_t [0:1];
    op_t  = '{6'b001000, 6'b001101};
    sel_t = '{4'b0011, 4'b0010};
    alu_t = '{3'd0, 3'd3};
    clear_stl();
    for (int k = 0; k < 2; k++) begin
      Opcode = op_t[k];
      ev[0] = v_if();
      ev[1] = v_id();
      ev[2] = e(4'd3, 5'b00000, sel_t[k], alu_t[k], 2'b00, 1'b0, 1'b0);
      ev[3] = e(4'd9, 5'b10100, sel_t[k], alu_t[k], 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
        Stall = stl[i];
        #1;
        checks++;
        if (outs !== ev[i]) begin
          errors++;
          $display("FAIL imm op=%h cyc%0d: got %h want %h", op_t[k], i, outs, ev[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_lw_sw();
    clear_stl();
    Opcode = 6'b100011;
    ev[0] = v_if();
    ev[1] = v_id();
    ev[2] = e(4'd4,  5'b00000, 4'b0011, 3'd0, 2'b00, 1'b0, 1'b0);
    ev[3] = e(4'd6,  5'b00010, 4'b0011, 3'd0, 2'b00, 1'b0, 1'b0);
    ev[4] = e(4'd10, 5'b10100, 4'b0111, 3'd0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      Stall = stl[i];
      #1;
      checks++;
      if (outs !== ev[i]) begin
        errors++;
        $display("FAIL lw cyc%0d: got %h want %h", i, outs, ev[i]);
      end
      @(negedge clk);
    end
    Opcode = 6'b101011;
    ev[2] = e(4'd4, 5'b00000, 4'b0011, 3'd0, 2'b00, 1'b0, 1'b0);
    ev[3] = e(4'd7, 5'b10001, 4'b0011, 3'd0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      Stall = stl[i];
      #1;
      checks++;
      if (outs !== ev[i]) begin
        errors++;
        $display("FAIL sw cyc%0d: got %h want %h", i, outs, ev[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    clear_stl();
    Opcode = 6'b000100;
    for (int k = 1; k >= 0; k--) begin
      Zero = k[0];
      ev[0] = v_if();
      ev[1] = v_id();
      ev[2] = e(4'd5, 5'b10000, 4'b0001, 3'd1, k[0] ? 2'b01 : 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        Stall = stl[i];
        #1;
        checks++;
        if (outs !== ev[i]) begin
          errors++;
          $display("FAIL beq zero=%0d cyc%0d: got %h want %h", k, i, outs, ev[i]);
        end
        @(negedge clk);
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_j_illegal();
    logic [5:0] op_t [0:2];
    logic [5:0] fn_t [0:2];
    op_t = '{6'b000010, 6'h3E, 6'b000000};
    fn_t = '{6'h20, 6'h00, 6'h21};
    clear_stl();
    for (int k = 0; k < 3; k++) begin
      Opcode = op_t[k];
      Funct  = fn_t[k];
      ev[0] = v_if();
      ev[1] = (k == 0) ? e(4'd1, 5'b10000, 4'b0000, 3'd0, 2'b10, 1'b0, 1'b0)
                       : e(4'd1, 5'b10000, 4'b0000, 3'd0, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
        Stall = stl[i];
        #1;
        checks++;
        if (outs !== ev[i]) begin
          errors++;
          $display("FAIL j_illegal op=%h fn=%h cyc%0d: got %h want %h",
                   op_t[k], fn_t[k], i, outs, ev[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_stall();
    // lw: stalled fetch, then three stalled MEM_RD cycles
    clear_stl();
    Opcode = 6'b100011;
    ev[0] = e(4'd0, 5'b00000, 4'b0000, 3'd0, 2'b00, 1'b0, 1'b0);
    ev[1] = v_if();
    ev[2] = v_id();
    ev[3] = e(4'd4,  5'b00000, 4'b0011, 3'd0, 2'b00, 1'b0, 1'b0);
    ev[4] = e(4'd6,  5'b00000, 4'b0011, 3'd0, 2'b00, 1'b0, 1'b0);
    ev[5] = ev[4];
    ev[6] = ev[4];
    ev[7] = e(4'd6,  5'b00010, 4'b0011, 3'd0, 2'b00, 1'b0, 1'b0);
    ev[8] = e(4'd10, 5'b10100, 4'b0111, 3'd0, 2'b00, 1'b0, 1'b0);
    stl[0] = 1'b1; stl[4] = 1'b1; stl[5] = 1'b1; stl[6] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      Stall = stl[i];
      #1;
      checks++;
      if (outs !== ev[i]) begin
        errors++;
        $display("FAIL stall_lw cyc%0d: got %h want %h", i, outs, ev[i]);
      end
      @(negedge clk);
    end
    // add stalled in WB_R re-issues PCWre/RegWre once unstalled
    clear_stl();
    Opcode = 6'b000000;
    Funct  = 6'h20;
    ev[0] = v_if();
    ev[1] = v_id();
    ev[2] = e(4'd2, 5'b00000, 4'b0000, 3'd0, 2'b00, 1'b0, 1'b0);
    ev[3] = e(4'd8, 5'b00000, 4'b1000, 3'd0, 2'b00, 1'b0, 1'b0);
    ev[4] = e(4'd8, 5'b10100, 4'b1000, 3'd0, 2'b00, 1'b0, 1'b0);
    stl[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Stall = stl[i];
      #1;
      checks++;
      if (outs !== ev[i]) begin
        errors++;
        $display("FAIL stall_wb cyc%0d: got %h want %h", i, outs, ev[i]);
      end
      @(negedge clk);
    end
    // j stalled in ID keeps its jump select but withholds PCWre
    clear_stl();
    Opcode = 6'b000010;
    ev[0] = v_if();
    ev[1] = e(4'd1, 5'b00000, 4'b0000, 3'd0, 2'b10, 1'b0, 1'b0);
    ev[2] = e(4'd1, 5'b10000, 4'b0000, 3'd0, 2'b10, 1'b0, 1'b0);
    stl[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Stall = stl[i];
      #1;
      checks++;
      if (outs !== ev[i]) begin
        errors++;
        $display("FAIL stall_j cyc%0d: got %h want %h", i, outs, ev[i]);
      end
      @(negedge clk);
    end
    Stall = 1'b0;
  endtask

  task automatic test_mid_reset();
    clear_stl();
    Opcode = 6'b000000;
    Funct  = 6'h20;
    ev[0] = v_if();
    ev[1] = v_id();
    ev[2] = e(4'd2, 5'b00000, 4'b0000, 3'd0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      Stall = stl[i];
      #1;
      checks++;
      if (outs !== ev[i]) begin
        errors++;
        $display("FAIL midrst_pre cyc%0d: got %h want %h", i, outs, ev[i]);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 20'h0) begin
      errors++;
      $display("FAIL midrst_abort: got %h want %h", outs, 20'h0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (outs !== 20'h0) begin
      errors++;
      $display("FAIL midrst_held: got %h want %h", outs, 20'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ev[3] = e(4'd8, 5'b10100, 4'b1000, 3'd0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      Stall = stl[i];
      #1;
      checks++;
      if (outs !== ev[i]) begin
        errors++;
        $display("FAIL midrst_rerun cyc%0d: got %h want %h", i, outs, ev[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_halt();
    clear_stl();
    Opcode = 6'b111111;
    ev[0] = v_if();
    ev[1] = v_id();
    for (int i = 2; i < 22; i++) ev[i] = e(4'd15, 5'b00000, 4'b0000, 3'd0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 22; i++) begin
      Stall = stl[i];
      #1;
      checks++;
      if (outs !== ev[i]) begin
        errors++;
        $display("FAIL halt cyc%0d: got %h want %h", i, outs, ev[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm();
    test_lw_sw();
    test_beq();
    test_j_illegal();
    test_stall();
    test_mid_reset();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
